// File: rtl/mdio_read_seq_ctrl.sv
// Bulk MDIO readback sequencer: walks data_sel/address space, issues one read per word,
// captures the fixed-latency result and hands {sel,addr,data} downstream over valid/ready.
module mdio_read_seq_ctrl #(
  parameter int ADDR_W = 15,
  parameter int SEL_W  = 7,
  parameter int RD_LAT = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_96path_en,
  input  logic [ADDR_W-1:0] cfg_addr_start,
  input  logic [ADDR_W-1:0] cfg_addr_end,
  input  logic [8:0]        rd_data,
  output logic              seq_rd_pulse,
  output logic [SEL_W-1:0]  seq_data_sel,
  output logic [ADDR_W-1:0] seq_mem_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  out_sel,
  output logic [ADDR_W-1:0] out_addr,
  output logic [8:0]        out_data,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_PUSH  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] addr_first;
  logic [ADDR_W-1:0] addr_last;
  logic [SEL_W-1:0]  sel_last;
  logic              at_addr_last;
  logic              last_word;

  always_comb begin
    at_addr_last = (seq_mem_addr == addr_last);
    last_word    = at_addr_last && (seq_data_sel == sel_last);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      addr_first   <= '0;
      addr_last    <= '0;
      sel_last     <= '0;
      seq_rd_pulse <= 1'b0;
      seq_data_sel <= '0;
      seq_mem_addr <= '0;
      out_valid    <= 1'b0;
      out_sel      <= '0;
      out_addr     <= '0;
      out_data     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      seq_rd_pulse <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state     <= S_IDLE;
        out_valid <= 1'b0;
        busy      <= 1'b0;
        aborted   <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              addr_first   <= cfg_addr_start;
              // end below start collapses to a single address per sel
              addr_last    <= (cfg_addr_end < cfg_addr_start) ? cfg_addr_start : cfg_addr_end;
              sel_last     <= cfg_96path_en ? SEL_W'(95) : SEL_W'(47);
              seq_data_sel <= '0;
              seq_mem_addr <= cfg_addr_start;
              seq_rd_pulse <= 1'b1;
              busy         <= 1'b1;
              state        <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            wait_cnt <= CNT_W'(RD_LAT - 1);
            state    <= S_WAIT;
          end
          S_WAIT: begin
            if (wait_cnt == '0) begin
              out_data  <= rd_data;
              out_sel   <= seq_data_sel;
              out_addr  <= seq_mem_addr;
              out_valid <= 1'b1;
              state     <= S_PUSH;
            end else begin
              wait_cnt <= wait_cnt - CNT_W'(1);
            end
          end
          S_PUSH: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (last_word) begin
                done  <= 1'b1;
                state <= S_FIN;
              end else begin
                if (at_addr_last) begin
                  seq_mem_addr <= addr_first;
                  seq_data_sel <= seq_data_sel + SEL_W'(1);
                end else begin
                  seq_mem_addr <= seq_mem_addr + ADDR_W'(1);
                end
                seq_rd_pulse <= 1'b1;
                state        <= S_ISSUE;
              end
            end
          end
          S_FIN: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
